// File: rtl/qrf_ctrl_pkg.sv
// Purpose: shared types, constants and width helpers for the QRF ping-pong bank controllers.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package qrf_ctrl_pkg;

  // Number of ping-pong channels that move together: Q real/imag and R real/imag.
  localparam int QRF_NUM_CHAN = 4;

  // Index width that never collapses to zero bits, even for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Snapshot of controller state for monitors. Eight bits covers the full 2..8 bank range.
  typedef struct packed {
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [7:0] count;
  } qrf_bank_state_t;

endpackage

// File: rtl/qrf_stall_watchdog.sv
// Purpose: counts consecutive blocked cycles without progress and flags when LIMIT is reached.
// Latency: flag rises on the edge where the count reaches LIMIT and drops one edge after progress.
// Backpressure: observes only; it never stalls anything.
module qrf_stall_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic blocked,
  input  logic progress,
  output logic flag
);

  localparam int CNTW = $clog2(LIMIT + 1);

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_next;

  // Next count: clear on progress or when nobody is waiting; otherwise count up and saturate.
  always_comb begin
    cnt_next = cnt;
    if (progress || !blocked) begin
      cnt_next = '0;
    end else if (cnt != CNTW'(LIMIT)) begin
      cnt_next = cnt + CNTW'(1);
    end
  end

  // Register the count and the flag so the flag never depends combinationally on the inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      flag <= (cnt_next == CNTW'(LIMIT));
    end
  end

endmodule

// File: rtl/qrf_pipo_bank_ctrl.sv
// Purpose: round-robin write/read bank ownership for the four QRF ping-pong channels, with a stall watchdog.
// Latency: a commit is visible to the consumer, and a release to the producer, one cycle after the pulse.
// Backpressure: i_full_n / t_empty_n are registered; a pulse made while the flag is low is dropped and logged as an error.
module qrf_pipo_bank_ctrl
  import qrf_ctrl_pkg::*;
#(
  parameter  int NUM_BANKS   = 2,
  parameter  int STALL_LIMIT = 1024,
  localparam int BW          = clog2_min1(NUM_BANKS),
  localparam int CW          = clog2_min1(NUM_BANKS + 1)
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          clr,
  input  logic          i_write,
  output logic          i_full_n,
  output logic [BW-1:0] i_bank,
  input  logic          t_read,
  output logic          t_empty_n,
  output logic [BW-1:0] t_bank,
  input  logic          prod_wait,
  input  logic          cons_wait,
  output logic [CW-1:0] occupancy,
  output logic          err_overflow,
  output logic          err_underflow,
  output logic          stall_flag
);

  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] count_next;
  logic          blocked;
  logic          progress;

  // Round-robin successor of a bank index.
  function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
    return (p == BW'(NUM_BANKS - 1)) ? '0 : p + BW'(1);
  endfunction

  // Accepts use the registered handshakes; a simultaneous commit and release leaves occupancy unchanged.
  always_comb begin
    wr_acc     = i_write & i_full_n;
    rd_acc     = t_read & t_empty_n;
    count_next = occupancy;
    if (wr_acc && !rd_acc) begin
      count_next = occupancy + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = occupancy - CW'(1);
    end
  end

  // Bank pointers, occupancy, handshakes and sticky errors; clr resets everything except the errors.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      i_bank        <= '0;
      t_bank        <= '0;
      occupancy     <= '0;
      i_full_n      <= 1'b1;
      t_empty_n     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (clr) begin
      i_bank    <= '0;
      t_bank    <= '0;
      occupancy <= '0;
      i_full_n  <= 1'b1;
      t_empty_n <= 1'b0;
    end else begin
      if (wr_acc) begin
        i_bank <= ptr_inc(i_bank);
      end
      if (rd_acc) begin
        t_bank <= ptr_inc(t_bank);
      end
      occupancy <= count_next;
      i_full_n  <= (count_next != CW'(NUM_BANKS));
      t_empty_n <= (count_next != '0);
      if (i_write && !i_full_n) begin
        err_overflow <= 1'b1;
      end
      if (t_read && !t_empty_n) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // A side is blocked when it is waiting and its handshake says no bank is available.
  always_comb begin
    blocked  = (prod_wait & ~i_full_n) | (cons_wait & ~t_empty_n);
    progress = wr_acc | rd_acc;
  end

  qrf_stall_watchdog #(
    .LIMIT (STALL_LIMIT)
  ) u_watchdog (
    .clock    (ap_clk),
    .reset    (ap_rst | clr),
    .blocked  (blocked),
    .progress (progress),
    .flag     (stall_flag)
  );

endmodule

// File: tb/tb_qrf_pipo_bank_ctrl.sv
module tb_qrf_pipo_bank_ctrl;
  import qrf_ctrl_pkg::*;

  localparam int NB_B = 3;
  localparam int LIM_B = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: two banks, watchdog limit 8 (directed tests)
  logic       a_rst, a_clr, a_wr, a_rd, a_pw, a_cw;
  logic       a_full_n, a_empty_n, a_ovf, a_udf, a_stall;
  logic [0:0] a_ib, a_tb;
  logic [1:0] a_occ;

  qrf_pipo_bank_ctrl #(.NUM_BANKS(2), .STALL_LIMIT(8)) dut_a (
    .ap_clk(clk), .ap_rst(a_rst), .clr(a_clr),
    .i_write(a_wr), .i_full_n(a_full_n), .i_bank(a_ib),
    .t_read(a_rd), .t_empty_n(a_empty_n), .t_bank(a_tb),
    .prod_wait(a_pw), .cons_wait(a_cw), .occupancy(a_occ),
    .err_overflow(a_ovf), .err_underflow(a_udf), .stall_flag(a_stall)
  );

  // Instance B: three banks, watchdog limit 5 (randomized against the model)
  logic       b_rst, b_clr, b_wr, b_rd, b_pw, b_cw;
  logic       b_full_n, b_empty_n, b_ovf, b_udf, b_stall;
  logic [1:0] b_ib, b_tb, b_occ;

  qrf_pipo_bank_ctrl #(.NUM_BANKS(NB_B), .STALL_LIMIT(LIM_B)) dut_b (
    .ap_clk(clk), .ap_rst(b_rst), .clr(b_clr),
    .i_write(b_wr), .i_full_n(b_full_n), .i_bank(b_ib),
    .t_read(b_rd), .t_empty_n(b_empty_n), .t_bank(b_tb),
    .prod_wait(b_pw), .cons_wait(b_cw), .occupancy(b_occ),
    .err_overflow(b_ovf), .err_underflow(b_udf), .stall_flag(b_stall)
  );

  typedef struct {
    logic clr, wr, rd, pw, cw;
    logic full_n, empty_n, ib, tb;
    logic [1:0] occ;
    logic ovf, udf, stall;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic clr, wr, rd, pw, cw,
                              input logic full_n, empty_n, ib, tb,
                              input logic [1:0] occ, input logic ovf, udf, stall);
    vec_t v;
    v.clr = clr; v.wr = wr; v.rd = rd; v.pw = pw; v.cw = cw;
    v.full_n = full_n; v.empty_n = empty_n; v.ib = ib; v.tb = tb;
    v.occ = occ; v.ovf = ovf; v.udf = udf; v.stall = stall;
    return v;
  endfunction

  task automatic cyc_a(input logic clr, wr, rd, pw, cw);
    a_clr = clr; a_wr = wr; a_rd = rd; a_pw = pw; a_cw = cw;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string name, input logic full_n, empty_n, ib, tb,
                         input logic [1:0] occ, input logic ovf, udf, stall);
    logic [8:0] got, exp;
    got = {a_full_n, a_empty_n, a_ib[0], a_tb[0], a_occ, a_ovf, a_udf, a_stall};
    exp = {full_n, empty_n, ib, tb, occ, ovf, udf, stall};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got {full_n,empty_n,ib,tb,occ,ovf,udf,stall}=%b expected %b", name, got, exp);
    end
  endtask

  // Reference model for instance B: lifetime commit/release totals; banks and occupancy follow arithmetically.
  int m_wr_tot, m_rd_tot, m_stall;
  bit m_ovf, m_udf;

  task automatic model_reset();
    m_wr_tot = 0; m_rd_tot = 0; m_stall = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_step(input bit clr, wr, rd, pw, cw);
    int occ;
    bit full, empty, wacc, racc, blk;
    occ   = m_wr_tot - m_rd_tot;
    full  = (occ == NB_B);
    empty = (occ == 0);
    if (clr) begin
      m_wr_tot = 0; m_rd_tot = 0; m_stall = 0;
    end else begin
      wacc = wr && !full;
      racc = rd && !empty;
      if (wr && full)  m_ovf = 1;
      if (rd && empty) m_udf = 1;
      blk = (pw && full) || (cw && empty);
      if (wacc || racc || !blk) m_stall = 0;
      else if (m_stall < LIM_B) m_stall++;
      if (wacc) m_wr_tot++;
      if (racc) m_rd_tot++;
    end
  endtask

  task automatic check_b(input string name);
    int occ;
    qrf_bank_state_t st;
    logic [10:0] got, exp;
    occ = m_wr_tot - m_rd_tot;
    st.wr_ptr = 8'(m_wr_tot % NB_B);
    st.rd_ptr = 8'(m_rd_tot % NB_B);
    st.count  = 8'(occ);
    got = {b_full_n, b_empty_n, b_ib, b_tb, b_occ, b_ovf, b_udf, b_stall};
    exp = {occ != NB_B, occ != 0, st.wr_ptr[1:0], st.rd_ptr[1:0], st.count[1:0],
           m_ovf, m_udf, m_stall == LIM_B};
    vectors++;
    if (got !== exp || occ > NB_B) begin
      miscompares++;
      $display("FAIL %s: got {full_n,empty_n,ib,tb,occ,ovf,udf,stall}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic cyc_b(input bit clr, wr, rd, pw, cw);
    b_clr = clr; b_wr = wr; b_rd = rd; b_pw = pw; b_cw = cw;
    model_step(clr, wr, rd, pw, cw);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps_i, wraps_t, writes;
    logic [1:0] prev_ib, prev_tb;

    a_rst = 1; a_clr = 0; a_wr = 0; a_rd = 0; a_pw = 0; a_cw = 0;
    b_rst = 1; b_clr = 0; b_wr = 0; b_rd = 0; b_pw = 0; b_cw = 0;

    //            clr wr rd pw cw  fn en ib tb occ ovf udf stl
    tbl[0]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0,   1, 1, 1, 0, 1,  0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0,   0, 1, 0, 0, 2,  0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,   0, 1, 0, 0, 2,  0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0,   1, 1, 0, 1, 1,  1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0,   1, 1, 0, 1, 1,  1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0,   1, 0, 0, 0, 0,  1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0,   1, 0, 0, 0, 0,  1, 1, 0);
    tbl[9]  = mk(0, 1, 1, 0, 0,   1, 1, 1, 0, 1,  1, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0,  1, 1, 0);
    tbl[11] = mk(1, 1, 1, 1, 1,   1, 0, 0, 0, 0,  1, 1, 0);
    tbl[12] = mk(0, 1, 0, 0, 1,   1, 1, 1, 0, 1,  1, 1, 0);
    tbl[13] = mk(0, 0, 1, 0, 0,   1, 0, 1, 1, 0,  1, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 1,   1, 0, 1, 1, 0,  1, 1, 0);
    tbl[15] = mk(0, 1, 1, 0, 0,   1, 1, 0, 1, 1,  1, 1, 0);
    tbl[16] = mk(0, 0, 1, 0, 0,   1, 0, 0, 0, 0,  1, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    a_rst = 0;
    check_a("reset_state", 1, 0, 0, 0, 2'd0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      cyc_a(tbl[i].clr, tbl[i].wr, tbl[i].rd, tbl[i].pw, tbl[i].cw);
      check_a($sformatf("row%0d", i), tbl[i].full_n, tbl[i].empty_n, tbl[i].ib, tbl[i].tb,
              tbl[i].occ, tbl[i].ovf, tbl[i].udf, tbl[i].stall);
    end

    // Fill, then hold the producer waiting on a full controller until the watchdog fires.
    cyc_a(0, 1, 0, 0, 0);
    cyc_a(0, 1, 0, 0, 0);
    check_a("fill", 0, 1, 0, 0, 2'd2, 1, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc_a(0, 0, 0, 1, 0);
      check_a($sformatf("stall_ramp%0d", i), 0, 1, 0, 0, 2'd2, 1, 1, i >= 8);
    end
    cyc_a(0, 0, 1, 1, 0);
    check_a("stall_release", 1, 1, 0, 1, 2'd1, 1, 1, 0);
    cyc_a(0, 1, 0, 1, 0);
    check_a("refill", 0, 1, 1, 1, 2'd2, 1, 1, 0);
    for (int i = 1; i <= 9; i++) cyc_a(0, 0, 0, 1, 0);
    check_a("stall_again", 0, 1, 1, 1, 2'd2, 1, 1, 1);
    cyc_a(1, 0, 0, 1, 0);
    check_a("clr_in_stall", 1, 0, 0, 0, 2'd0, 1, 1, 0);
    a_rst = 1;
    cyc_a(0, 0, 0, 0, 0);
    a_rst = 0;
    check_a("rst_clears_err", 1, 0, 0, 0, 2'd0, 0, 0, 0);

    // Randomized traffic on the three-bank instance, phased to reach full, empty and stall.
    b_rst = 0;
    model_reset();
    check_b("b_reset");
    wraps_i = 0; wraps_t = 0; writes = 0;
    for (int i = 0; i < 600; i++) begin
      int phase;
      bit clr, wr, rd;
      phase = (i / 40) % 3;
      clr = ($urandom_range(0, 79) == 0);
      case (phase)
        0: begin wr = $urandom_range(0, 1) == 1; rd = $urandom_range(0, 1) == 1; end
        1: begin wr = $urandom_range(0, 7) != 0; rd = $urandom_range(0, 9) == 0; end
        default: begin wr = $urandom_range(0, 9) == 0; rd = $urandom_range(0, 7) != 0; end
      endcase
      prev_ib = b_ib;
      prev_tb = b_tb;
      cyc_b(clr, wr, rd, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (wr && !clr) writes++;
      if (prev_ib == 2'd2 && b_ib == 2'd0 && !clr) wraps_i++;
      if (prev_tb == 2'd2 && b_tb == 2'd0 && !clr) wraps_t++;
      check_b($sformatf("rand%0d", i));
    end
    vectors++;
    if (wraps_i < 1 || wraps_t < 1 || writes < 10) begin
      miscompares++;
      $display("FAIL wrap_seen: got i_wraps=%0d t_wraps=%0d writes=%0d required >=1,>=1,>=10",
               wraps_i, wraps_t, writes);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
